// File: rtl/pico_mem_dma_if.sv
// PicoRV32 native memory bus (valid/ready, addr, wdata, wstrb, rdata).
// The DMA engine drives the master side; memory/IO responders take the slave side.
interface pico_mem_dma_if;
  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/pico_mem_dma.sv
// Word-copy DMA initiator on the PicoRV32 native bus: one read then one write per word.
// Optional running checksum of read data when DMA_CHECKSUM_EN is defined.
module pico_mem_dma #(
  parameter int TIMEOUT = 255,
  parameter int LEN_W   = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  output logic             busy,
  output logic             done,
  output logic             error,
`ifdef DMA_CHECKSUM_EN
  output logic [31:0]      checksum,
`endif
  pico_mem_dma_if.master   mem
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t           state;
  logic [31:0]      src;
  logic [31:0]      dst;
  logic [LEN_W-1:0] cnt;
  logic [TW-1:0]    tcnt;
  logic             timeout_hit;

  // Abort fires on the waiting cycle that brings the wait count up to TIMEOUT.
  assign timeout_hit   = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT - 1));
  assign mem.mem_instr = 1'b0;

  // NOTE: state uses non-blocking assignments so every register updates from
  // pre-edge values; mixing in blocking writes would make ordering matter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: datapath registers are reset as well, so bus outputs are
      // defined (zero) straight out of reset rather than only the control bits.
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      mem.mem_valid <= 1'b0;
      mem.mem_wstrb <= 4'h0;
      mem.mem_addr  <= 32'h0;
      mem.mem_wdata <= 32'h0;
      src           <= 32'h0;
      dst           <= 32'h0;
      cnt           <= '0;
      tcnt          <= '0;
`ifdef DMA_CHECKSUM_EN
      checksum      <= 32'h0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            error <= 1'b0;
`ifdef DMA_CHECKSUM_EN
            checksum <= 32'h0;
`endif
            if (len_words != '0) begin
              src           <= {src_addr[31:2], 2'b00};
              dst           <= {dst_addr[31:2], 2'b00};
              cnt           <= len_words;
              tcnt          <= '0;
              busy          <= 1'b1;
              mem.mem_valid <= 1'b1;
              mem.mem_addr  <= {src_addr[31:2], 2'b00};
              mem.mem_wstrb <= 4'h0;
              state         <= READ;
            end else begin
              done <= 1'b1;
            end
          end
        end

        READ, WRITE: begin
          if (mem.mem_ready) begin
            tcnt <= '0;
            if (state == READ) begin
              mem.mem_wdata <= mem.mem_rdata;
              mem.mem_addr  <= dst;
              mem.mem_wstrb <= 4'hF;
`ifdef DMA_CHECKSUM_EN
              checksum <= checksum + mem.mem_rdata;
`endif
              state <= WRITE;
            end else begin
              src <= src + 32'd4;
              dst <= dst + 32'd4;
              cnt <= cnt - LEN_W'(1);
              if (cnt == LEN_W'(1)) begin
                mem.mem_valid <= 1'b0;
                mem.mem_wstrb <= 4'h0;
                busy          <= 1'b0;
                done          <= 1'b1;
                state         <= IDLE;
              end else begin
                mem.mem_addr  <= src + 32'd4;
                mem.mem_wstrb <= 4'h0;
                state         <= READ;
              end
            end
          end else if (timeout_hit) begin
            mem.mem_valid <= 1'b0;
            mem.mem_wstrb <= 4'h0;
            error         <= 1'b1;
            done          <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end else if (TIMEOUT != 0) begin
            tcnt <= tcnt + TW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pico_mem_dma.sv
// Scoreboard bench for pico_mem_dma: expected bus transactions are queued at stimulus
// time and a separate monitor pops/compares them on every accepted request.
module tb_pico_mem_dma;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = 32'h0;
  logic [31:0] dst_addr = 32'h0;
  logic [15:0] len_words = 16'h0;
  logic        busy, done, error;
`ifdef DMA_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  pico_mem_dma_if bus();

  pico_mem_dma #(.TIMEOUT(TIMEOUT), .LEN_W(16)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len_words (len_words),
    .busy      (busy),
    .done      (done),
    .error     (error),
`ifdef DMA_CHECKSUM_EN
    .checksum  (checksum),
`endif
    .mem       (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          wr;
    logic [31:0] data;
    int          at_edge;
  } txn_t;

  txn_t exp_q[$];

  task automatic push(input logic [31:0] addr, input bit wr, input logic [31:0] data, input int at_edge);
    txn_t t;
    t.addr = addr; t.wr = wr; t.data = data; t.at_edge = at_edge;
    exp_q.push_back(t);
  endtask

  // Responder: ready one cycle after valid, acting on the request when ready rises.
  logic [31:0] mem [256];
  bit resp_en = 1'b0;
  int wcnt = 0;
  always @(negedge clk) begin
    if (resp_en) begin
      if (bus.mem_ready) begin
        bus.mem_ready = 1'b0;
        wcnt = bus.mem_valid ? 1 : 0;
      end else if (bus.mem_valid) begin
        if (wcnt >= 1) begin
          bus.mem_ready = 1'b1;
          wcnt = 0;
          if (bus.mem_wstrb != 4'h0) mem[bus.mem_addr[9:2]] = bus.mem_wdata;
          else bus.mem_rdata = mem[bus.mem_addr[9:2]];
        end else begin
          wcnt = 1;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: anything with valid&ready here is accepted on the next posedge.
  int valid_cycles = 0;
  always begin
    @(negedge clk);
    #1;
    if (bus.mem_valid) valid_cycles++;
    if (bus.mem_valid && bus.mem_ready) begin
      check("sb_txn_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        txn_t t;
        t = exp_q.pop_front();
        check("sb_addr", bus.mem_addr, t.addr);
        check("sb_wstrb", 32'(bus.mem_wstrb), t.wr ? 32'hF : 32'h0);
        if (t.wr) check("sb_wdata", bus.mem_wdata, t.data);
        if (t.at_edge >= 0) check("sb_accept_edge", 32'(cyc + 1), 32'(t.at_edge));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // Returns with cyc equal to the edge on which start was sampled.
  task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l, output int n);
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; len_words = l;
    step();
    start = 1'b0;
    n = cyc;
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        at = cyc;
        break;
      end
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1);
  end

  initial begin
    int n, at, vc0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]   = 32'h1111_1111;
    mem[1]   = 32'h2222_2222;
    mem[255] = 32'hAAAA_5555;

    // Reset state
    step(); step();
    check("rst_valid", 32'(bus.mem_valid), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_wstrb", 32'(bus.mem_wstrb), 32'd0);
    check("rst_addr",  bus.mem_addr,  32'd0);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    check("rst_instr", 32'(bus.mem_instr), 32'd0);
    resetn = 1'b1;
    step();

    // Basic two-word copy
    resp_en = 1'b1;
    do_start(32'h0, 32'h40, 16'd2, n);
    push(32'h0,  1'b0, 32'h0,         n + 2);
    push(32'h40, 1'b1, 32'h1111_1111, n + 4);
    push(32'h4,  1'b0, 32'h0,         n + 6);
    push(32'h44, 1'b1, 32'h2222_2222, n + 8);
    check("basic_busy_start",  32'(busy), 32'd1);
    check("basic_valid_start", 32'(bus.mem_valid), 32'd1);
    wait_done(40, at);
    check("basic_done_edge", 32'(at), 32'(n + 8));
    check("basic_busy_end", 32'(busy), 32'd0);
    step();
    check("basic_done_pulse", 32'(done), 32'd0);
    check("basic_mem16", mem[16], 32'h1111_1111);
    check("basic_mem17", mem[17], 32'h2222_2222);
`ifdef DMA_CHECKSUM_EN
    check("basic_checksum", checksum, 32'h3333_3333);
`endif

    // Zero-length command
    vc0 = valid_cycles;
    do_start(32'h8, 32'h48, 16'd0, n);
    check("len0_done", 32'(done), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    step();
    check("len0_done_pulse", 32'(done), 32'd0);
    check("len0_no_valid", 32'(valid_cycles - vc0), 32'd0);

    // Timeout with a responder that never answers
    resp_en = 1'b0;
    vc0 = valid_cycles;
    do_start(32'h100, 32'h140, 16'd1, n);
    wait_done(40, at);
    check("to_done_edge", 32'(at), 32'(n + TIMEOUT));
    check("to_error", 32'(error), 32'd1);
    check("to_busy",  32'(busy),  32'd0);
    check("to_valid", 32'(bus.mem_valid), 32'd0);
    step();
    check("to_valid_cycles", 32'(valid_cycles - vc0), 32'(TIMEOUT));
    check("to_error_sticky", 32'(error), 32'd1);

    // Recovery clears error
    resp_en = 1'b1;
    do_start(32'h4, 32'h180, 16'd1, n);
    push(32'h4,   1'b0, 32'h0,         n + 2);
    push(32'h180, 1'b1, 32'h2222_2222, n + 4);
    check("rec_error_cleared", 32'(error), 32'd0);
    wait_done(40, at);
    check("rec_done_edge", 32'(at), 32'(n + 4));
    check("rec_mem96", mem[96], 32'h2222_2222);
`ifdef DMA_CHECKSUM_EN
    check("rec_checksum", checksum, 32'h2222_2222);
`endif
    step();

    // start while busy is ignored
    do_start(32'h0, 32'h80, 16'd1, n);
    push(32'h0,  1'b0, 32'h0,         n + 2);
    push(32'h80, 1'b1, 32'h1111_1111, n + 4);
    start = 1'b1; src_addr = 32'h200; dst_addr = 32'h300; len_words = 16'd5;
    step();
    start = 1'b0;
    wait_done(40, at);
    check("busy_ign_done_edge", 32'(at), 32'(n + 4));
    check("busy_ign_mem32", mem[32], 32'h1111_1111);
    step(); step();
    check("busy_ign_idle", 32'(busy), 32'd0);
    check("busy_ign_mem192", mem[192], 32'h0);

    // Source address wrap-around
    do_start(32'hFFFF_FFFC, 32'h200, 16'd2, n);
    push(32'hFFFF_FFFC, 1'b0, 32'h0,         n + 2);
    push(32'h200,       1'b1, 32'hAAAA_5555, n + 4);
    push(32'h0,         1'b0, 32'h0,         n + 6);
    push(32'h204,       1'b1, 32'h1111_1111, n + 8);
    wait_done(40, at);
    check("wrap_done_edge", 32'(at), 32'(n + 8));
    check("wrap_mem128", mem[128], 32'hAAAA_5555);
    check("wrap_mem129", mem[129], 32'h1111_1111);
`ifdef DMA_CHECKSUM_EN
    check("wrap_checksum", checksum, 32'hBBBB_6666);
`endif
    step();

    // Unaligned addresses are truncated to word alignment
    do_start(32'h3, 32'h103, 16'd1, n);
    push(32'h0,   1'b0, 32'h0,         n + 2);
    push(32'h100, 1'b1, 32'h1111_1111, n + 4);
    wait_done(40, at);
    check("align_done_edge", 32'(at), 32'(n + 4));
    check("align_mem64", mem[64], 32'h1111_1111);
    step();

    // Asynchronous reset in the middle of a read
    resp_en = 1'b0;
    do_start(32'h10, 32'h20, 16'd3, n);
    step(); step();
    check("mid_pre_valid", 32'(bus.mem_valid), 32'd1);
    #1 resetn = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.mem_valid), 32'd0);
    check("mid_rst_busy",  32'(busy),  32'd0);
    check("mid_rst_done",  32'(done),  32'd0);
    check("mid_rst_error", 32'(error), 32'd0);
    check("mid_rst_addr",  bus.mem_addr, 32'd0);
    step();
    resetn = 1'b1;
    step();
    vc0 = valid_cycles;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    step();
    bus.mem_ready = 1'b0;
    step(); step();
    check("mid_post_valid", 32'(bus.mem_valid), 32'd0);
    check("mid_post_busy",  32'(busy), 32'd0);
    check("mid_post_done",  32'(done), 32'd0);
    check("mid_post_no_valid", 32'(valid_cycles - vc0), 32'd0);
    check("mid_post_wdata", bus.mem_wdata, 32'd0);

    // A zero-length start also clears a sticky error
    do_start(32'h100, 32'h140, 16'd1, n);
    wait_done(40, at);
    check("to2_error", 32'(error), 32'd1);
    step();
    do_start(32'h0, 32'h0, 16'd0, n);
    check("len0_clr_done",  32'(done),  32'd1);
    check("len0_clr_error", 32'(error), 32'd0);
    step();

    check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pico_mem_dma.md
Name: pico_mem_dma

Overview:
- Bus-initiator word-copy engine on the PicoRV32 native memory interface (valid/ready, addr, wdata, wstrb, rdata).
- Drives the same interface that the on-chip memory/IO responder serves, as the master side.
- Copies len_words 32-bit words from src_addr to dst_addr: one read, then one write per word.
- Sits beside the core behind a bus arbiter; also usable standalone to preload memory or poke the LED/switch IO window.

Parameters:
- TIMEOUT, 255: max cycles a request may wait for mem_ready before abort; 0 disables the timeout.
- LEN_W, 16: width of the word-count input.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  single-cycle command strobe
- src_addr  in  32  source byte address; bits [1:0] ignored
- dst_addr  in  32  destination byte address; bits [1:0] ignored
- len_words  in  LEN_W  number of words to copy
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- error  out  1  sticky timeout flag
- mem_valid  out  1  request valid
- mem_instr  out  1  tied 0
- mem_ready  in  1  responder accept
- mem_addr  out  32  request address
- mem_wdata  out  32  write data
- mem_wstrb  out  4  byte strobes; 0 means read
- mem_rdata  in  32  read data, valid when mem_ready=1
- checksum  out  32  present only with DMA_CHECKSUM_EN

Behaviour:
- Reset (async, resetn=0): state IDLE; busy, done, error, mem_valid = 0; mem_wstrb=0; mem_addr, mem_wdata = 0. Takes effect immediately, including mid-transfer. Any mem_ready arriving afterwards is ignored.
- All outputs are registered.
- States: IDLE, READ, WRITE.
- IDLE + start, len_words>0:
  - Latch src/dst with low bits cleared; latch count.
  - Clear error.
  - busy=1; mem_valid=1, mem_addr=src, mem_wstrb=0.
  - Go to READ.
- IDLE + start, len_words=0: done=1 for one cycle; error cleared; no bus activity; stay IDLE.
- start while busy: ignored.
- Handshake:
  - Request fields stay stable while mem_valid=1 and mem_ready=0.
  - A transfer completes on the edge where mem_valid=1 and mem_ready=1 are sampled together.
  - The next request may be presented in the following cycle.
- READ accept edge:
  - Capture mem_rdata into mem_wdata.
  - mem_addr=dst, mem_wstrb=4'hF; go to WRITE.
- WRITE accept edge:
  - src and dst += 4, mod 2^32 (wraps).
  - count -= 1.
  - If count becomes 0: mem_valid=0, mem_wstrb=0, busy=0, done=1 for one cycle, go to IDLE.
  - Otherwise: mem_addr=src, mem_wstrb=0, go to READ.
- Timing with a responder that asserts ready one cycle after valid: 2 cycles per access, 4 cycles per word. done and busy fall are set on the final write accept edge.
- Timeout:
  - Counter clears on each new request.
  - Counter increments every cycle with mem_valid=1 and mem_ready=0.
  - When it reaches TIMEOUT (nonzero): mem_valid=0, mem_wstrb=0, error=1, done pulse, busy=0, IDLE.
  - error holds until the next accepted start or reset.
- mem_ready sampled while mem_valid=0: ignored.

Optional Feature:
- Macro: DMA_CHECKSUM_EN.
- Defined:
  - checksum port exists.
  - Cleared to 0 on every accepted start.
  - On each READ accept edge, checksum += mem_rdata mod 2^32.
  - Holds its value after done, including after a timeout abort.
- Undefined: port and adder absent; all other behaviour identical.

Test Plan:
- Reset: assert resetn=0 mid-READ with mem_valid=1 -> mem_valid, busy, done, error all 0 immediately, before the next clk edge; a later mem_ready pulse produces no activity.
- Basic copy:
  - Stimulus: memory[0]=0x11111111, memory[1]=0x22222222; start at edge N with src=0x0, dst=0x40, len=2; responder asserts ready one cycle after valid.
  - Accepts at N+2 rd 0x0, N+4 wr 0x40 wstrb F, N+6 rd 0x4, N+8 wr 0x44.
  - done high only after edge N+8; memory[16..17] match the source; checksum=0x33333333.
- len_words=0 -> done pulse on the edge after start; mem_valid never asserted; busy stays 0.
- Timeout: TIMEOUT=8, responder never ready -> mem_valid drops after 8 waiting cycles; error=1, done pulse, busy=0. Next start with a good responder clears error and completes normally.
- start re-pulsed with different addresses while busy -> ignored; original transfer completes unchanged.
- Wrap-around: src=0xFFFFFFFC, len=2 -> second read mem_addr=0x00000000. src=0x3 is treated as 0x0.
